// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types and constants for the UART command-frame controller.
// Frame layout on the wire: HDR, CMD, DATA, CHK with CHK = CMD ^ DATA.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      HUNT,
      GET_CMD,
      GET_DATA,
      GET_CHK,
      EXEC
   } state_t;

   localparam logic [7:0] CMD_LED   = 8'h01;
   localparam logic [7:0] CMD_MOTOR = 8'h02;
   localparam logic [7:0] CMD_STOP  = 8'h03;

   // Checksum byte a well-formed frame must carry for the given CMD/DATA pair.
   function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] data);
      return cmd ^ data;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-FF synchronizer followed by a registered rising-edge pulse.
// A rise on din produces a one-cycle pulse three clk edges later.
module sync_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic pulse
);

   logic [2:0] sync_q;

   // Shift the asynchronous level through the synchronizer and flag a 0->1 step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         pulse  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample its pre-edge input;
         // blocking ones here would collapse the chain into a single stage.
         sync_q <= {sync_q[1:0], din};
         pulse  <= sync_q[1] & ~sync_q[2];
      end
   end

endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: assembles 4-byte command frames from the UART receiver,
// checks CHK = CMD ^ DATA, and drives the LED and motor control registers.
// Optional motor watchdog is built when UART_FRAME_WDOG_EN is defined.
module uart_frame_ctrl
   import uart_frame_pkg::*;
#(
   parameter logic [7:0]  HDR_BYTE    = 8'hAA,
   parameter logic [23:0] TIMEOUT_CYC = 24'd491520,
`ifdef UART_FRAME_WDOG_EN
   parameter logic [27:0] WDOG_CYC    = 28'd49152000,
`endif
   parameter int          ERR_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_done,
   input  logic [7:0]       rx_data,
   output logic             rx_en,
   output logic [1:0]       led,
   output logic             motor_en,
   output logic             motor_dir,
   output logic [6:0]       motor_duty,
   output logic             cmd_valid,
   output logic [ERR_W-1:0] err_cnt,
   output logic             busy
);

   localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYC - 24'd1;

   state_t        state, state_nx;
   logic [23:0]   timer, timer_nx;
   logic [7:0]    cmd_q, data_q;
   logic          byte_stb;
   logic          frame_err;
   logic          wdog_fire;
   logic [1:0]    err_inc;
   logic [ERR_W:0] err_sum;

   sync_edge_det u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (rx_done),
      .pulse (byte_stb)
   );

   assign cmd_valid = (state == EXEC);
   assign busy      = (state != HUNT);

   // Framing FSM: advance on each byte, drop the frame on bad checksum or inter-byte timeout.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path infers a latch.
      state_nx  = state;
      timer_nx  = timer;
      frame_err = 1'b0;
      case (state)
         HUNT: begin
            timer_nx = '0;
            if (byte_stb && rx_data == HDR_BYTE) state_nx = GET_CMD;
         end
         GET_CMD, GET_DATA, GET_CHK: begin
            if (byte_stb) begin
               // A byte landing on the timeout cycle still counts.
               timer_nx = '0;
               if (state == GET_CMD)                         state_nx = GET_DATA;
               else if (state == GET_DATA)                   state_nx = GET_CHK;
               else if (rx_data == frame_chk(cmd_q, data_q)) state_nx = EXEC;
               else begin
                  state_nx  = HUNT;
                  frame_err = 1'b1;
               end
            end else if (timer == TIMEOUT_LAST) begin
               timer_nx  = '0;
               state_nx  = HUNT;
               frame_err = 1'b1;
            end else begin
               timer_nx = timer + 24'd1;
            end
         end
         EXEC: begin
            timer_nx = '0;
            state_nx = HUNT;
         end
         default: state_nx = HUNT;
      endcase
   end

   // State, timer, frame field capture and receiver gating.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= HUNT;
         timer  <= '0;
         cmd_q  <= '0;
         data_q <= '0;
         rx_en  <= 1'b0;
      end else begin
         state <= state_nx;
         timer <= timer_nx;
         rx_en <= (state_nx != EXEC);
         if (byte_stb && state == GET_CMD)  cmd_q  <= rx_data;
         if (byte_stb && state == GET_DATA) data_q <= rx_data;
      end
   end

`ifdef UART_FRAME_WDOG_EN
   localparam logic [27:0] WDOG_LAST = WDOG_CYC - 28'd1;
   logic [27:0] wdog_cnt;

   assign wdog_fire = !cmd_valid && (wdog_cnt == WDOG_LAST);

   // Motor watchdog: restarts on every accepted frame, stops the motor when it expires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                       wdog_cnt <= '0;
      else if (cmd_valid || wdog_fire) wdog_cnt <= '0;
      else                             wdog_cnt <= wdog_cnt + 28'd1;
   end
`else
   assign wdog_fire = 1'b0;
`endif

   // Command registers change only in EXEC (or on watchdog expiry), never mid-frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led        <= 2'b00;
         motor_en   <= 1'b0;
         motor_dir  <= 1'b0;
         motor_duty <= 7'd0;
      end else begin
         if (state == EXEC) begin
            case (cmd_q)
               CMD_LED: led <= data_q[1:0];
               CMD_MOTOR: begin
                  motor_dir  <= data_q[7];
                  motor_duty <= data_q[6:0];
                  motor_en   <= (data_q[6:0] != 7'd0);
               end
               CMD_STOP: begin
                  motor_en   <= 1'b0;
                  motor_duty <= 7'd0;
               end
               default: ;
            endcase
         end
         if (wdog_fire) begin
            motor_en   <= 1'b0;
            motor_duty <= 7'd0;
         end
      end
   end

   // A frame error and a watchdog expiry may coincide, so the counter can step by two.
   assign err_inc = {1'b0, frame_err} + {1'b0, wdog_fire};
   assign err_sum = {1'b0, err_cnt} + {{(ERR_W-1){1'b0}}, err_inc};

   // Saturating error counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             err_cnt <= '0;
      else if (err_sum[ERR_W]) err_cnt <= '1;
      else                   err_cnt <= err_sum[ERR_W-1:0];
   end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed and randomized frames against a queue-based frame model.
// Honors UART_FRAME_WDOG_EN for the watchdog scenario.
module tb_uart_frame_ctrl;

   localparam int          T       = 64;
   localparam int          ERR_W   = 4;
   localparam int          ERR_MAX = 15;
   localparam logic [7:0]  HDR     = 8'hAA;
`ifdef UART_FRAME_WDOG_EN
   localparam int          W       = 1000;
`endif

   logic             clk     = 1'b0;
   logic             reset   = 1'b0;
   logic             rx_done = 1'b0;
   logic [7:0]       rx_data = 8'h00;
   logic             rx_en;
   logic [1:0]       led;
   logic             motor_en;
   logic             motor_dir;
   logic [6:0]       motor_duty;
   logic             cmd_valid;
   logic [ERR_W-1:0] err_cnt;
   logic             busy;

   uart_frame_ctrl #(
      .HDR_BYTE    (HDR),
      .TIMEOUT_CYC (24'(T)),
`ifdef UART_FRAME_WDOG_EN
      .WDOG_CYC    (28'(W)),
`endif
      .ERR_W       (ERR_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_done    (rx_done),
      .rx_data    (rx_data),
      .rx_en      (rx_en),
      .led        (led),
      .motor_en   (motor_en),
      .motor_dir  (motor_dir),
      .motor_duty (motor_duty),
      .cmd_valid  (cmd_valid),
      .err_cnt    (err_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed { int at; logic [7:0] b; } stb_t;
   stb_t       stb_q[$];      // byte arrivals: edge index at which the controller sees them
   logic [7:0] frame[$];      // bytes of the frame collected so far (empty = hunting)
   int         cyc     = 0;
   int         idle_m  = 0;
   int         err_m   = 0;
   int         wd_m    = 0;
   bit         exec_m  = 1'b0;
   bit         rx_en_m = 1'b0;
   logic [1:0] led_m   = 2'b00;
   bit         en_m    = 1'b0;
   bit         dir_m   = 1'b0;
   logic [6:0] duty_m  = 7'd0;

   int checks = 0;
   int errors = 0;
   int cv_cnt = 0;
   int rxlow_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      stb_q.delete();
      frame.delete();
      idle_m  = 0;
      err_m   = 0;
      wd_m    = 0;
      exec_m  = 1'b0;
      rx_en_m = 1'b0;
      led_m   = 2'b00;
      en_m    = 1'b0;
      dir_m   = 1'b0;
      duty_m  = 7'd0;
   endtask

   task automatic apply_cmd(input logic [7:0] c, input logic [7:0] d);
      if (c == 8'h01) led_m = d[1:0];
      else if (c == 8'h02) begin
         dir_m  = d[7];
         duty_m = d[6:0];
         en_m   = (d[6:0] != 7'd0);
      end else if (c == 8'h03) begin
         en_m   = 1'b0;
         duty_m = 7'd0;
      end
   endtask

   always @(posedge clk or posedge reset) begin : model
      bit         stb;
      logic [7:0] b;
      bit         was_exec;
      int         inc;
      if (reset) model_reset();
      else begin
         cyc++;
         stb = 1'b0;
         b   = 8'h00;
         while (stb_q.size() > 0 && stb_q[0].at < cyc) stb_q.delete(0);
         if (stb_q.size() > 0 && stb_q[0].at == cyc) begin
            stb = 1'b1;
            b   = stb_q[0].b;
            stb_q.delete(0);
         end
         was_exec = exec_m;
         inc      = 0;
         if (exec_m) begin
            apply_cmd(frame[1], frame[2]);
            frame.delete();
            exec_m = 1'b0;
            idle_m = 0;
         end else if (frame.size() == 0) begin
            idle_m = 0;
            if (stb && b == HDR) frame.push_back(b);
         end else if (stb) begin
            idle_m = 0;
            frame.push_back(b);
            if (frame.size() == 4) begin
               if (frame[3] == (frame[1] ^ frame[2])) exec_m = 1'b1;
               else begin
                  inc++;
                  frame.delete();
               end
            end
         end else if (idle_m == T - 1) begin
            inc++;
            frame.delete();
            idle_m = 0;
         end else idle_m++;
`ifdef UART_FRAME_WDOG_EN
         if (was_exec) wd_m = 0;
         else if (wd_m == W - 1) begin
            en_m   = 1'b0;
            duty_m = 7'd0;
            inc++;
            wd_m   = 0;
         end else wd_m++;
`else
         if (was_exec) wd_m = 0;
`endif
         err_m   = (err_m + inc > ERR_MAX) ? ERR_MAX : err_m + inc;
         rx_en_m = !exec_m;
      end
   end

   // Cycle-by-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      check("rx_en",      32'(rx_en),      32'(rx_en_m));
      check("led",        32'(led),        32'(led_m));
      check("motor_en",   32'(motor_en),   32'(en_m));
      check("motor_dir",  32'(motor_dir),  32'(dir_m));
      check("motor_duty", 32'(motor_duty), 32'(duty_m));
      check("cmd_valid",  32'(cmd_valid),  32'(exec_m));
      check("busy",       32'(busy),       32'(exec_m || frame.size() != 0));
      check("err_cnt",    32'(err_cnt),    32'(err_m));
      if (!reset) begin
         if (cmd_valid) cv_cnt++;
         if (!rx_en)    rxlow_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   // Called #1 after an edge; the byte reaches the controller on the 4th following edge.
   task automatic send_byte(input logic [7:0] b, input int hold = 2, input int low = 3);
      rx_data = b;
      rx_done = 1'b1;
      stb_q.push_back('{at: cyc + 4, b: b});
      repeat (hold) @(posedge clk);
      #1 rx_done = 1'b0;
      repeat (low) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
      send_byte(HDR);
      send_byte(c);
      send_byte(d);
      send_byte(k);
      idle(2);
   endtask

   task automatic do_reset();
      rx_done = 1'b0;
      reset   = 1'b1;
      idle(2);
      reset   = 1'b0;
      idle(1);
   endtask

   initial begin : watchdog_timer
      #5_000_000;
      $display("FAIL sim_time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin : main
      logic [7:0] c, d, k, g;
      int         sel, gi;
      #1 reset = 1'b1;
      idle(3);
      check("rst_rx_en",     32'(rx_en),      32'd0);
      check("rst_led",       32'(led),        32'd0);
      check("rst_motor_en",  32'(motor_en),   32'd0);
      check("rst_duty",      32'(motor_duty), 32'd0);
      check("rst_cmd_valid", 32'(cmd_valid),  32'd0);
      check("rst_err",       32'(err_cnt),    32'd0);
      check("rst_busy",      32'(busy),       32'd0);
      reset = 1'b0;
      idle(1);
      check("rx_en_first_cycle", 32'(rx_en), 32'd1);

      // LED frame: one cmd_valid pulse, rx_en low for exactly one cycle.
      cv_cnt = 0;
      rxlow_cnt = 0;
      send_frame(8'h01, 8'h03, 8'h02);
      check("led_frame_led",   32'(led),     32'd3);
      check("led_frame_pulse", 32'(cv_cnt),  32'd1);
      check("led_frame_rxen",  32'(rxlow_cnt), 32'd1);
      check("led_frame_err",   32'(err_cnt), 32'd0);

      // Motor run, then stop keeps direction.
      send_frame(8'h02, 8'hC0, 8'hC2);
      check("motor_dir",  32'(motor_dir),  32'd1);
      check("motor_duty", 32'(motor_duty), 32'd64);
      check("motor_en",   32'(motor_en),   32'd1);
      send_frame(8'h03, 8'h00, 8'h03);
      check("stop_en",   32'(motor_en),   32'd0);
      check("stop_duty", 32'(motor_duty), 32'd0);
      check("stop_dir",  32'(motor_dir),  32'd1);

      // Bad checksum, then leading garbage before a valid frame.
      send_frame(8'h01, 8'h03, 8'h00);
      check("badchk_led",  32'(led),     32'd3);
      check("badchk_err",  32'(err_cnt), 32'd1);
      check("badchk_busy", 32'(busy),    32'd0);
      send_byte(8'h55);
      send_byte(8'h13);
      send_frame(8'h01, 8'h01, 8'h00);
      check("garbage_led", 32'(led),     32'd1);
      check("garbage_err", 32'(err_cnt), 32'd1);

      // Inter-byte timeout drops the partial frame.
      send_byte(HDR);
      send_byte(8'h02);
      idle(T + 4);
      check("timeout_err",  32'(err_cnt),   32'd2);
      check("timeout_busy", 32'(busy),      32'd0);
      check("timeout_dir",  32'(motor_dir), 32'd1);

      // Byte arriving exactly on the timeout cycle is processed.
      send_byte(HDR, 2, T - 2);
      send_byte(8'h01);
      check("edge_busy", 32'(busy),    32'd1);
      check("edge_err",  32'(err_cnt), 32'd2);
      send_byte(8'h03);
      send_byte(8'h02);
      idle(2);
      check("edge_led", 32'(led), 32'd3);

      // One cycle later the frame has already timed out.
      send_byte(HDR, 2, T - 1);
      send_byte(8'h01);
      idle(2);
      check("late_err",  32'(err_cnt), 32'd3);
      check("late_busy", 32'(busy),    32'd0);
      send_frame(8'h01, 8'h00, 8'h01);
      check("late_recover_led", 32'(led), 32'd0);

      // Error counter saturates.
      do_reset();
      repeat (20) send_frame(8'h01, 8'h03, 8'h00);
      check("sat_err", 32'(err_cnt), 32'(ERR_MAX));

`ifdef UART_FRAME_WDOG_EN
      do_reset();
      send_frame(8'h02, 8'hC0, 8'hC2);
      check("wdog_pre_en", 32'(motor_en), 32'd1);
      idle(W + 5);
      check("wdog_en",   32'(motor_en),   32'd0);
      check("wdog_duty", 32'(motor_duty), 32'd0);
      check("wdog_err",  32'(err_cnt),    32'd1);
`endif

      // Reset in the middle of a frame.
      do_reset();
      send_frame(8'h02, 8'h85, 8'h87);
      send_byte(HDR);
      send_byte(8'h01);
      reset = 1'b1;
      #2;
      check("midrst_en",   32'(motor_en),   32'd0);
      check("midrst_dir",  32'(motor_dir),  32'd0);
      check("midrst_duty", 32'(motor_duty), 32'd0);
      check("midrst_busy", 32'(busy),       32'd0);
      check("midrst_rxen", 32'(rx_en),      32'd0);
      idle(2);
      reset = 1'b0;
      idle(1);
      check("midrst_rxen_after", 32'(rx_en), 32'd1);

      // Randomized traffic.
      for (int i = 0; i < 250; i++) begin
         sel = $urandom_range(0, 9);
         c   = 8'($urandom_range(0, 3));
         if (c == 8'h00) c = 8'($urandom);
         d   = 8'($urandom);
         k   = c ^ d;
         if (sel <= 1) begin
            send_byte(8'($urandom), $urandom_range(2, 3), $urandom_range(3, 6));
         end else if (sel <= 5) begin
            send_frame(c, d, k);
         end else if (sel <= 7) begin
            g = 8'($urandom_range(1, 255));
            send_frame(c, d, k ^ g);
         end else if (sel == 8) begin
            gi = $urandom_range(0, 2);
            send_byte(HDR, 2, (gi == 0) ? $urandom_range(T - 8, T + 4) : 3);
            send_byte(c,   2, (gi == 1) ? $urandom_range(T - 8, T + 4) : 3);
            send_byte(d,   2, (gi == 2) ? $urandom_range(T - 8, T + 4) : 3);
            send_byte(k);
            idle(2);
         end else begin
            send_byte(HDR);
            send_byte(c);
            idle($urandom_range(T - 4, T + 6));
         end
      end
      idle(T + 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
Command-frame controller between the UART receive path and the LED/motor outputs.
- Runs in the clk (49.152 MHz) domain.
- Consumes bytes and done pulses from the UART receiver (clk_main domain), gates the receiver enable, and assembles fixed 4-byte frames.
- Validates each frame's checksum and applies commands to the LED and motor control registers.
- Replaces ad-hoc parser sequencing with an explicit framing/timeout state machine.

Parameters:
HDR_BYTE, 8'hAA, frame start marker.
TIMEOUT_CYC, 24'd491520, max clk cycles between bytes inside a frame (10 ms).
WDOG_CYC, 28'd49152000, motor watchdog period in clk cycles (1 s; used only with the optional feature).
ERR_W, 8, width of the error counter.

Ports:
clk  input  1  system clock, 49.152 MHz
reset  input  1  asynchronous, active-high
rx_done  input  1  byte-done level from receiver; clk_main domain, high ≥1 clk_main period
rx_data  input  8  received byte; stable while rx_done is high and until the next byte
rx_en  output  1  receiver enable
led  output  2  LED drive register
motor_en  output  1  motor enable
motor_dir  output  1  motor direction
motor_duty  output  7  PWM duty, 0..127
cmd_valid  output  1  one-cycle pulse when a frame is accepted
err_cnt  output  ERR_W  saturating count of checksum and timeout errors
busy  output  1  high in any state other than HUNT

Behaviour:
Reset values (all outputs): rx_en=0, led=2'b00, motor_en=0, motor_dir=0, motor_duty=0, cmd_valid=0, err_cnt=0, busy=0; state=HUNT; timer=0.

Input synchronisation:
- rx_done passes through a 2-FF synchronizer, then rising-edge detection → byte_stb.
- Latency: 3 clk cycles from rx_done rising to byte_stb.
- rx_data is sampled on byte_stb.

Receiver enable:
- rx_en=1 on the first cycle after reset and in every state except EXEC.
- rx_en=0 for exactly one cycle in EXEC.

Frame format: HDR, CMD, DATA, CHK, where CHK = CMD ^ DATA.

States:
- HUNT: byte_stb with HDR_BYTE → GET_CMD. Any other byte is discarded silently (no error).
- GET_CMD: byte_stb → latch CMD → GET_DATA.
- GET_DATA: byte_stb → latch DATA → GET_CHK.
- GET_CHK: byte_stb → if byte == CMD^DATA → EXEC; else err_cnt+1 → HUNT.
- EXEC: single cycle; apply command, pulse cmd_valid → HUNT.

Commands:
- 0x01: led ← DATA[1:0].
- 0x02: motor_dir ← DATA[7]; motor_duty ← DATA[6:0]; motor_en ← (DATA[6:0] != 0).
- 0x03: motor_en ← 0, motor_duty ← 0; motor_dir unchanged.
- Any other CMD: no register change, cmd_valid still pulses (frame is well-formed).

Inter-byte timeout:
- Timer clears on every byte_stb and in HUNT; increments in GET_CMD, GET_DATA and GET_CHK.
- When timer reaches TIMEOUT_CYC-1: err_cnt+1, → HUNT. The partial frame is dropped and registers are unchanged.
- If byte_stb and timeout occur in the same cycle, byte_stb wins (timer clears, byte processed).

Error counter: err_cnt saturates at all-ones and never wraps.

Back-to-back frames: HDR arriving the cycle after EXEC is accepted, since HUNT samples on the cycle it is entered.

Reset mid-frame: asynchronous return to reset values. No partial register update is ever visible, because registers change only in EXEC.

Optional Feature:
Macro: UART_FRAME_WDOG_EN.
- Defined: watchdog counter clears on every cmd_valid and increments otherwise. On reaching WDOG_CYC-1: motor_en←0, motor_duty←0, err_cnt+1, counter clears. led is unaffected.
- Undefined: no watchdog logic; motor registers hold indefinitely.

Decomposition:
Shared package uart_frame_pkg:
- state enum (HUNT, GET_CMD, GET_DATA, GET_CHK, EXEC);
- command constants CMD_LED=8'h01, CMD_MOTOR=8'h02, CMD_STOP=8'h03.

One sub-module: sync_edge_det, a 2-FF synchronizer plus rising-edge pulse, reusable for other clk_main→clk crossings.

Test Plan:
- Frame AA 01 03 02 → led=2'b11, one-cycle cmd_valid, err_cnt=0, rx_en low exactly one cycle.
- Frame AA 02 C0 C2 → motor_dir=1, motor_duty=7'd64, motor_en=1; then AA 03 00 03 → motor_en=0, duty=0, dir stays 1.
- Bad checksum AA 01 03 00 → led unchanged, err_cnt=1, state HUNT; the following valid frame is still accepted.
- Bytes 55 13 then AA 01 01 00 → leading garbage ignored, led=2'b01, err_cnt=0.
- AA 02, then idle for TIMEOUT_CYC cycles → err_cnt=1, busy=0, motor unchanged; also check byte_stb landing exactly on the timeout cycle is processed.
- With UART_FRAME_WDOG_EN and WDOG_CYC=1000: motor frame, then 1000 idle cycles → motor_en=0, duty=0, err_cnt=1; assert reset mid-frame → all outputs at reset values.
